// File: rtl/choice1_pfd_tdc_ckt.sv
// Phase/frequency detector with time-to-digital readout: measures rise-to-rise and
// fall-to-fall spacing of two asynchronous signals in dco_clk cycles.
module choice1_pfd_tdc_ckt #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       dco_clk,
   input  logic       reset,
   input  logic       enable_PFD_TDC,
   input  logic       select_PFD_input,
   input  logic       ref_clk,
   input  logic       gated_dco_clk,
   input  logic       external1,
   input  logic       external2,
   output logic       early,
   output logic       fine_done_pre,
   output logic [4:0] counter_rise,
   output logic [4:0] counter_fall,
   output logic [7:0] bs,
   output logic [8:0] vernier
);
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   typedef struct packed {
      state_t     st;
      logic       lead_a;
      logic       tmo;
      logic [7:0] cnt;
   } chan_t;

   localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

   // Shared next-state rule for the rise and fall channels; edges are already one-cycle strobes.
   function automatic chan_t chan_next(input chan_t c, input logic a_e, input logic b_e,
                                       input logic en);
      chan_t n;
      n = c;
      case (c.st)
         IDLE: begin
            if (a_e || b_e) begin
               n.st     = (a_e && b_e) ? DONE : WAIT;
               n.lead_a = a_e && !b_e;
               n.tmo    = 1'b0;
               n.cnt    = 8'd0;
            end
         end
         WAIT: begin
            if (c.cnt != 8'hFF) n.cnt = c.cnt + 8'd1;
            if (c.lead_a ? b_e : a_e) begin
               n.st = DONE;
            end else if (n.cnt >= TMO_CNT) begin
               n.st  = DONE;
               n.tmo = 1'b1;
            end
         end
         default: n.st = IDLE;
      endcase
      if (!en) n.st = IDLE;
      return n;
   endfunction

   function automatic logic [4:0] sat31(input logic [7:0] m);
      return (m > 8'd31) ? 5'd31 : m[4:0];
   endfunction

   logic [2:0] a_sync_q, a_sync_d, b_sync_q, b_sync_d;
   chan_t      rise_q, rise_d, fall_q, fall_d;
   logic       early_q, early_d, fine_done_pre_q, fine_done_pre_d;
   logic [4:0] counter_rise_q, counter_rise_d, counter_fall_q, counter_fall_d;
   logic [7:0] bs_q, bs_d;
   logic [8:0] vernier_q, vernier_d;
   logic       a_in, b_in, a_rise, b_rise, a_fall, b_fall;
   logic [7:0] rise_mag, fall_mag;

   always_comb begin
      a_in     = select_PFD_input ? external1 : ref_clk;
      b_in     = select_PFD_input ? external2 : gated_dco_clk;
      a_sync_d = {a_sync_q[1:0], a_in};
      b_sync_d = {b_sync_q[1:0], b_in};
      a_rise   = a_sync_q[1] & ~a_sync_q[2];
      b_rise   = b_sync_q[1] & ~b_sync_q[2];
      a_fall   = ~a_sync_q[1] & a_sync_q[2];
      b_fall   = ~b_sync_q[1] & b_sync_q[2];

      rise_d   = chan_next(rise_q, a_rise, b_rise, enable_PFD_TDC);
      fall_d   = chan_next(fall_q, a_fall, b_fall, enable_PFD_TDC);
      rise_mag = rise_q.tmo ? 8'hFF : rise_q.cnt;
      fall_mag = fall_q.tmo ? 8'hFF : fall_q.cnt;

      early_d         = early_q;
      fine_done_pre_d = 1'b0;
      counter_rise_d  = counter_rise_q;
      counter_fall_d  = counter_fall_q;
      bs_d            = bs_q;
      vernier_d       = vernier_q;

      // Results are captured only while enabled, so dropping enable in DONE discards them.
      if (enable_PFD_TDC && rise_q.st == DONE) begin
         early_d         = rise_q.lead_a;
         fine_done_pre_d = 1'b1;
         counter_rise_d  = sat31(rise_mag);
         bs_d            = {bs_q[6:0], rise_q.lead_a};
         vernier_d       = rise_q.lead_a ? {1'b0, rise_mag} : 9'd0 - {1'b0, rise_mag};
      end
      if (enable_PFD_TDC && fall_q.st == DONE) counter_fall_d = sat31(fall_mag);
   end

   always_ff @(posedge dco_clk) begin
      if (reset) begin
         a_sync_q        <= '0;
         b_sync_q        <= '0;
         rise_q          <= '0;
         fall_q          <= '0;
         early_q         <= 1'b0;
         fine_done_pre_q <= 1'b0;
         counter_rise_q  <= '0;
         counter_fall_q  <= '0;
         bs_q            <= '0;
         vernier_q       <= '0;
      end else begin
         a_sync_q        <= a_sync_d;
         b_sync_q        <= b_sync_d;
         rise_q          <= rise_d;
         fall_q          <= fall_d;
         early_q         <= early_d;
         fine_done_pre_q <= fine_done_pre_d;
         counter_rise_q  <= counter_rise_d;
         counter_fall_q  <= counter_fall_d;
         bs_q            <= bs_d;
         vernier_q       <= vernier_d;
      end
   end

   assign early         = early_q;
   assign fine_done_pre = fine_done_pre_q;
   assign counter_rise  = counter_rise_q;
   assign counter_fall  = counter_fall_q;
   assign bs            = bs_q;
   assign vernier       = vernier_q;
endmodule

// File: tb/tb_choice1_pfd_tdc_ckt.sv
// Directed and randomized edge-pair scenarios checked against an interval-based reference model.
module tb_choice1_pfd_tdc_ckt;
   localparam int TIMEOUT = 255;

   logic       dco_clk = 1'b0;
   logic       reset, enable_PFD_TDC, select_PFD_input;
   logic       ref_clk, gated_dco_clk, external1, external2;
   logic       early, fine_done_pre;
   logic [4:0] counter_rise, counter_fall;
   logic [7:0] bs;
   logic [8:0] vernier;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // Reference state: history of rise decisions plus the last held results.
   logic       hist[$];
   logic       exp_early;
   logic [4:0] exp_cr, exp_cf;
   logic [8:0] exp_vern;

   choice1_pfd_tdc_ckt #(.TIMEOUT(TIMEOUT)) dut (
      .dco_clk(dco_clk), .reset(reset), .enable_PFD_TDC(enable_PFD_TDC),
      .select_PFD_input(select_PFD_input), .ref_clk(ref_clk), .gated_dco_clk(gated_dco_clk),
      .external1(external1), .external2(external2), .early(early), .fine_done_pre(fine_done_pre),
      .counter_rise(counter_rise), .counter_fall(counter_fall), .bs(bs), .vernier(vernier)
   );

   always #5 dco_clk = ~dco_clk;

   always @(negedge dco_clk) if (fine_done_pre === 1'b1) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge dco_clk);
   endtask

   task automatic set_ab(input logic sel, input logic a, input logic b);
      select_PFD_input = sel;
      ref_clk          = sel ? 1'b0 : a;
      gated_dco_clk    = sel ? 1'b0 : b;
      external1        = sel ? a : 1'b0;
      external2        = sel ? b : 1'b0;
   endtask

   // A rises at cycle ta for wa cycles, B at tb for wb cycles; a negative start means never.
   task automatic drive_pair(input logic sel, input int ta, input int tb, input int wa, input int wb);
      int fa, fb, last;
      logic av, bv;
      fa   = (ta < 0) ? -1 : ta + wa;
      fb   = (tb < 0) ? -1 : tb + wb;
      last = ((fa > fb) ? fa : fb) + 1;
      for (int t = 0; t <= last; t++) begin
         av = (ta >= 0) && (t >= ta) && (t < fa);
         bv = (tb >= 0) && (t >= tb) && (t < fb);
         set_ab(sel, av, bv);
         @(negedge dco_clk);
      end
   endtask

   // Interval between two event times; a missing event or too long a gap means a timeout.
   task automatic tdc_model(input int ta, input int tb, output logic a_led, output int mag);
      if (tb < 0) begin
         a_led = 1'b1;
         mag   = 255;
      end else if (ta < 0) begin
         a_led = 1'b0;
         mag   = 255;
      end else begin
         a_led = ta < tb;
         mag   = (ta > tb) ? ta - tb : tb - ta;
         if (mag >= TIMEOUT) mag = 255;
      end
   endtask

   function automatic logic [4:0] sat(input int m);
      return (m > 31) ? 5'd31 : 5'(m);
   endfunction

   function automatic logic [7:0] bs_exp();
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         if (i < hist.size()) r[i] = hist[hist.size() - 1 - i];
      return r;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".early"}, 32'(early), 32'(exp_early));
      chk({tag, ".done"}, 32'(fine_done_pre), 32'd0);
      chk({tag, ".crise"}, 32'(counter_rise), 32'(exp_cr));
      chk({tag, ".cfall"}, 32'(counter_fall), 32'(exp_cf));
      chk({tag, ".bs"}, 32'(bs), 32'(bs_exp()));
      chk({tag, ".vernier"}, 32'(vernier), 32'(exp_vern));
   endtask

   task automatic meas(input string tag, input logic sel, input int ta, input int tb,
                       input int wa, input int wb);
      logic a_led, f_led;
      int   mag, fmag, p0;
      p0 = pulses;
      drive_pair(sel, ta, tb, wa, wb);
      settle(320);
      tdc_model(ta, tb, a_led, mag);
      tdc_model((ta < 0) ? -1 : ta + wa, (tb < 0) ? -1 : tb + wb, f_led, fmag);
      hist.push_back(a_led);
      exp_early = a_led;
      exp_cr    = sat(mag);
      exp_vern  = a_led ? 9'(mag) : 9'(512 - mag);
      exp_cf    = sat(fmag);
      check_all(tag);
      chk({tag, ".pulses"}, 32'(pulses - p0), 32'd1);
   endtask

   initial begin
      int p0;
      reset          = 1'b1;
      enable_PFD_TDC = 1'b1;
      set_ab(1'b0, 1'b0, 1'b0);
      settle(4);
      reset = 1'b0;
      settle(2);
      exp_early = 1'b0; exp_cr = '0; exp_cf = '0; exp_vern = '0;
      check_all("reset");

      meas("ref_leads6", 1'b0, 0, 6, 10, 10);
      chk("ref_leads6.vern_abs", 32'(vernier), 32'd6);
      meas("ext2_leads40", 1'b1, 40, 0, 10, 10);
      chk("ext2_leads40.vern_abs", 32'(vernier), 32'h1D8);
      meas("same_cycle", 1'b0, 3, 3, 8, 8);
      meas("fall3_rise5", 1'b0, 0, 5, 20, 18);
      meas("timeout_a_only", 1'b0, 0, -1, 20, 1);
      chk("timeout_a_only.vern_abs", 32'(vernier), 32'd255);

      for (int i = 0; i < 8; i++) begin
         meas($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
              int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
      end

      // Edges while disabled: nothing changes.
      p0 = pulses;
      enable_PFD_TDC = 1'b0;
      drive_pair(1'b0, 0, 4, 10, 10);
      settle(20);
      enable_PFD_TDC = 1'b1;
      settle(20);
      check_all("disabled");
      chk("disabled.pulses", 32'(pulses - p0), 32'd0);

      // Enable dropped mid-measurement aborts it.
      p0 = pulses;
      set_ab(1'b0, 1'b1, 1'b0);
      settle(10);
      enable_PFD_TDC = 1'b0;
      set_ab(1'b0, 1'b1, 1'b1);
      settle(5);
      set_ab(1'b0, 1'b0, 1'b0);
      settle(10);
      enable_PFD_TDC = 1'b1;
      settle(300);
      check_all("abort");
      chk("abort.pulses", 32'(pulses - p0), 32'd0);

      // Reset while waiting for the second edge.
      p0 = pulses;
      set_ab(1'b0, 1'b1, 1'b0);
      settle(10);
      reset = 1'b1;
      set_ab(1'b0, 1'b0, 1'b0);
      settle(3);
      reset = 1'b0;
      settle(300);
      hist.delete();
      exp_early = 1'b0; exp_cr = '0; exp_cf = '0; exp_vern = '0;
      check_all("reset_mid_wait");
      chk("reset_mid_wait.pulses", 32'(pulses - p0), 32'd0);

      meas("after_reset", 1'b0, 0, 6, 10, 10);
      chk("after_reset.bs_abs", 32'(bs), 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
